// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_pkg                                                                     |
// | Opcodes, flag bit positions and shared helpers for the pipelined N-bit ALU. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    localparam int OPW = 3;

    typedef logic [OPW-1:0] opcode_t;

    localparam opcode_t OP_ADD  = 3'd0;
    localparam opcode_t OP_SUB  = 3'd1;
    localparam opcode_t OP_AND  = 3'd2;
    localparam opcode_t OP_OR   = 3'd3;
    localparam opcode_t OP_XOR  = 3'd4;
    localparam opcode_t OP_ADDC = 3'd5;
    localparam opcode_t OP_SHL  = 3'd6;
    localparam opcode_t OP_SHR  = 3'd7;

    localparam int FLG_C   = 3;
    localparam int FLG_Z   = 2;
    localparam int FLG_NEG = 1;
    localparam int FLG_V   = 0;

    // Bitwise ops leave the chained carry untouched; everything else refreshes it.
    function automatic logic op_updates_carry(input opcode_t op);
        return !((op == OP_AND) || (op == OP_OR) || (op == OP_XOR));
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// +----------------------------------------------------------------------------+
// | alu_core                                                                    |
// | Combinational N-bit ALU datapath with C/Z/NEG/V flags.                      |
// | Define ALU_SAT_EN to saturate ADD/SUB/ADDC as signed values.                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_core
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [OPW-1:0] op,
    input  logic           cin,
    output logic [N-1:0]   res,
    output logic [3:0]     flags,
    output logic           cout
);

    logic [N-1:0] b_eff;
    logic         c_in_eff;
    logic [N:0]   sum;
    logic [N-1:0] r_raw;
    logic         c_raw;
    logic         v_raw;

    always_comb begin
        b_eff    = (op == OP_SUB) ? ~b : b;
        c_in_eff = (op == OP_SUB) ? 1'b1 : ((op == OP_ADDC) ? cin : 1'b0);
        sum      = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, c_in_eff};
        r_raw    = sum[N-1:0];
        c_raw    = sum[N];
        v_raw    = 1'b0;
        case (op)
            OP_AND: begin r_raw = a & b; c_raw = 1'b0; end
            OP_OR:  begin r_raw = a | b; c_raw = 1'b0; end
            OP_XOR: begin r_raw = a ^ b; c_raw = 1'b0; end
            OP_SHL: begin r_raw = {a[N-2:0], 1'b0}; c_raw = a[N-1]; end
            OP_SHR: begin r_raw = {1'b0, a[N-1:1]}; c_raw = a[0];   end
            // ADD, SUB, ADDC: overflow when like-signed operands give an unlike-signed sum
            default: v_raw = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
        endcase

`ifdef ALU_SAT_EN
        // Overflow direction follows the (shared) operand sign
        if (v_raw) begin
            res = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            res = r_raw;
        end
`else
        res = r_raw;
`endif

        flags          = 4'b0000;
        flags[FLG_C]   = c_raw;
        flags[FLG_Z]   = (res == '0);
        flags[FLG_NEG] = res[N-1];
        flags[FLG_V]   = v_raw;
        cout           = c_raw;
    end

endmodule

`default_nettype wire

// File: rtl/nbit_alu_pipe.sv
// +----------------------------------------------------------------------------+
// | nbit_alu_pipe                                                               |
// | Two-stage valid/ready pipelined N-bit ALU with chained carry for ADDC.      |
// | Define ALU_SAT_EN to saturate ADD/SUB/ADDC as signed values.                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module nbit_alu_pipe #(
    parameter int N   = 8,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic [OPW-1:0] in_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_res,
    output logic [3:0]     out_flags
);

    import alu_pkg::*;

    logic           s1_valid;
    logic [N-1:0]   s1_a;
    logic [N-1:0]   s1_b;
    logic [OPW-1:0] s1_op;
    logic           s2_valid;
    logic           carry_q;
    logic           s1_adv;
    logic           s2_adv;
    logic [N-1:0]   core_res;
    logic [3:0]     core_flags;
    logic           core_cout;

    // Each stage may load whenever its own slot frees up this cycle
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    alu_core #(
        .N (N)
    ) u_core (
        .a     (s1_a),
        .b     (s1_b),
        .op    (s1_op),
        .cin   (carry_q),
        .res   (core_res),
        .flags (core_flags),
        .cout  (core_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_op <= in_op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_res   <= '0;
            out_flags <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_res   <= core_res;
                out_flags <= core_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (s2_adv && s1_valid && op_updates_carry(s1_op)) begin
            carry_q <= core_cout;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nbit_alu_pipe.sv
// +----------------------------------------------------------------------------+
// | tb_nbit_alu_pipe                                                            |
// | Directed and randomized checks of nbit_alu_pipe at N=8 and N=16.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_nbit_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        iv8, ir8, ov8, or8;
    logic [7:0]  a8, b8, res8;
    logic [2:0]  op8;
    logic [3:0]  fl8;

    logic        iv16, ir16, ov16, or16;
    logic [15:0] a16, b16, res16;
    logic [2:0]  op16;
    logic [3:0]  fl16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nbit_alu_pipe #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8), .in_op(op8),
        .out_valid(ov8), .out_ready(or8), .out_res(res8), .out_flags(fl8)
    );

    nbit_alu_pipe #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16), .in_op(op16),
        .out_valid(ov16), .out_ready(or16), .out_res(res16), .out_flags(fl16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        op8 = op; a8 = a; b8 = b; iv8 = 1'b1;
    endtask

    // Single op through an empty pipe with out_ready high
    task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef);
        drive8(op, a, b);
        chk({tag, "_in_ready"}, ir8, 1);
        tick;
        iv8 = 1'b0;
        tick;
        chk({tag, "_valid"}, ov8, 1);
        chk({tag, "_res"}, res8, er);
        chk({tag, "_flags"}, fl8, ef);
        tick;
    endtask

    // Reference arithmetic on plain integers; flags packed {C,Z,NEG,V}
    function automatic void model(input int n, input logic [2:0] op, input longint a,
                                  input longint b, input bit cin, output longint r,
                                  output logic [3:0] f, output bit cout);
        longint m, half, sa, sb, ex, u;
        bit     c, v;
        m    = longint'(1) << n;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        ex   = 0;
        c    = 0;
        v    = 0;
        cout = cin;
        case (op)
            3'd0: begin u = a + b;       ex = sa + sb;       c = (u >= m); end
            3'd1: begin u = a - b + m;   ex = sa - sb;       c = (a >= b); end
            3'd2: u = a & b;
            3'd3: u = a | b;
            3'd4: u = a ^ b;
            3'd5: begin u = a + b + longint'(cin); ex = sa + sb + longint'(cin); c = (u >= m); end
            3'd6: begin u = a * 2;       c = (a >= half); end
            default: begin u = a / 2;    c = (a % 2) != 0; end
        endcase
        r = u % m;
        if (op == 3'd0 || op == 3'd1 || op == 3'd5) begin
            v = (ex >= half) || (ex < -half);
`ifdef ALU_SAT_EN
            if (v) r = (ex > 0) ? half - 1 : half;
`endif
        end
        if (!(op == 3'd2 || op == 3'd3 || op == 3'd4)) cout = c;
        f = {c, r == 0, r >= half, v};
    endfunction

    logic [19:0] q8[$];
    logic [19:0] q16[$];
    int          n8, n16;
    bit          c8, c16, acc8, acc16;
    longint      mr;
    logic [3:0]  mf;

    initial begin
        rst_n = 1'b0;
        iv8 = 0; or8 = 1; a8 = 0; b8 = 0; op8 = 0;
        iv16 = 0; or16 = 1; a16 = 0; b16 = 0; op16 = 0;
        tick; tick;
        rst_n = 1'b1;

        chk("rst_out_valid", ov8, 0);
        chk("rst_out_res", res8, 0);
        chk("rst_out_flags", fl8, 0);
        chk("rst_in_ready", ir8, 1);

        // Latency: accepted at one edge, visible after the next
        drive8(3'd0, 8'hFF, 8'h01);
        tick;
        iv8 = 1'b0;
        chk("lat_not_yet", ov8, 0);
        tick;
        chk("lat_valid", ov8, 1);
        chk("lat_res", res8, 8'h00);
        chk("lat_flags", fl8, 4'b1100);
        tick;
        chk("lat_drained", ov8, 0);

        // ADD then two ADDCs back-to-back
        drive8(3'd0, 8'hFF, 8'h01);
        tick;
        drive8(3'd5, 8'h00, 8'h00);
        tick;
        drive8(3'd5, 8'h00, 8'h00);
        chk("b2b_add_res", res8, 8'h00);
        chk("b2b_add_flags", fl8, 4'b1100);
        tick;
        iv8 = 1'b0;
        chk("b2b_addc1_res", res8, 8'h01);
        chk("b2b_addc1_flags", fl8, 4'b0000);
        tick;
        chk("b2b_addc2_res", res8, 8'h00);
        chk("b2b_addc2_flags", fl8, 4'b0100);
        tick;

`ifdef ALU_SAT_EN
        run8("sub_ovf", 3'd1, 8'h80, 8'h01, 8'h80, 4'b1011);
`else
        run8("sub_ovf", 3'd1, 8'h80, 8'h01, 8'h7F, 4'b1001);
`endif
        run8("sub_neg", 3'd1, 8'h03, 8'h05, 8'hFE, 4'b0010);
        run8("and", 3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000);
        run8("shr", 3'd7, 8'h81, 8'h00, 8'h40, 4'b1000);

        // Backpressure: two ops fill the pipe, the third must wait
        or8 = 1'b0;
        drive8(3'd0, 8'h10, 8'h20);
        tick;
        drive8(3'd4, 8'hF0, 8'h0F);
        tick;
        drive8(3'd3, 8'h00, 8'h00);
        chk("bp_full_ready", ir8, 0);
        tick;
        chk("bp_stall_ready", ir8, 0);
        chk("bp_stall_valid", ov8, 1);
        chk("bp_stall_res", res8, 8'h30);
        tick;
        chk("bp_hold_res", res8, 8'h30);
        chk("bp_hold_flags", fl8, 4'b0000);
        or8 = 1'b1;
        #1;
        chk("bp_release_ready", ir8, 1);
        tick;
        drive8(3'd6, 8'h81, 8'h00);
        chk("bp_op2_res", res8, 8'hFF);
        chk("bp_op2_flags", fl8, 4'b0010);
        tick;
        iv8 = 1'b0;
        chk("bp_op3_res", res8, 8'h00);
        chk("bp_op3_flags", fl8, 4'b0100);
        tick;
        chk("bp_op4_res", res8, 8'h02);
        chk("bp_op4_flags", fl8, 4'b1000);
        tick;
        chk("bp_empty", ov8, 0);

        // Reset with both stages full, carry_q set by the first op
        or8 = 1'b0;
        drive8(3'd0, 8'hFF, 8'h01);
        tick;
        drive8(3'd0, 8'hFF, 8'h01);
        tick;
        iv8 = 1'b0;
        chk("mid_full_valid", ov8, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ov8, 0);
        chk("mid_rst_res", res8, 0);
        chk("mid_rst_flags", fl8, 0);
        tick;
        rst_n = 1'b1;
        or8 = 1'b1;
        chk("mid_rst_ready", ir8, 1);
        run8("post_rst_addc", 3'd5, 8'h01, 8'h01, 8'h02, 4'b0000);

        // Randomized traffic on both widths against the reference model
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        n8 = 0; n16 = 0; c8 = 0; c16 = 0;
        for (int cyc = 0; cyc < 40000 && (n8 < 2000 || n16 < 2000 ||
             q8.size() > 0 || q16.size() > 0); cyc++) begin
            or8  = ($urandom % 4) != 0;
            or16 = ($urandom % 4) != 0;
            if (!iv8 && n8 < 2000 && ($urandom % 3) != 0) begin
                op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); iv8 = 1'b1;
            end
            if (!iv16 && n16 < 2000 && ($urandom % 3) != 0) begin
                op16 = 3'($urandom); a16 = 16'($urandom); b16 = 16'($urandom); iv16 = 1'b1;
            end
            #1;
            if (ov8) begin
                if (q8.size() == 0) begin
                    chk("rnd8_extra_output", 1, 0);
                end else begin
                    chk("rnd8_res", res8, q8[0][7:0]);
                    chk("rnd8_flags", fl8, q8[0][19:16]);
                    if (or8) void'(q8.pop_front());
                end
            end
            if (ov16) begin
                if (q16.size() == 0) begin
                    chk("rnd16_extra_output", 1, 0);
                end else begin
                    chk("rnd16_res", res16, q16[0][15:0]);
                    chk("rnd16_flags", fl16, q16[0][19:16]);
                    if (or16) void'(q16.pop_front());
                end
            end
            acc8  = iv8 && ir8;
            acc16 = iv16 && ir16;
            if (acc8) begin
                model(8, op8, longint'(a8), longint'(b8), c8, mr, mf, c8);
                q8.push_back({mf, mr[15:0]});
                n8++;
            end
            if (acc16) begin
                model(16, op16, longint'(a16), longint'(b16), c16, mr, mf, c16);
                q16.push_back({mf, mr[15:0]});
                n16++;
            end
            tick;
            if (acc8)  iv8  = 1'b0;
            if (acc16) iv16 = 1'b0;
        end
        chk("rnd8_issued", n8, 2000);
        chk("rnd16_issued", n16, 2000);
        chk("rnd8_drained", q8.size(), 0);
        chk("rnd16_drained", q16.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nbit_alu_pipe.md
Name: nbit_alu_pipe

Overview:
- Parametrised successor to the team's combinational N-bit adder.
- Two-stage pipelined N-bit ALU with valid/ready handshake on both sides.
- Provides carry, zero, negative and overflow flags, plus a carry register for multi-word add chains (ADDC).
- Sits between an operand source and a result consumer in the datapath labs; fully backpressure-safe.

Parameters:
- N, 8, operand/result width in bits (N >= 2)
- OPW, 3, opcode width (fixed; do not override)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  ALU can accept this cycle
- in_a  in  N  operand A
- in_b  in  N  operand B
- in_op  in  OPW  opcode
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_res  out  N  result
- out_flags  out  4  {C, Z, NEG, V}

Behaviour:
- Opcodes:
  - 000 ADD: A+B
  - 001 SUB: A+~B+1
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 ADDC: A+B+carry_q
  - 110 SHL: A<<1, C=A[N-1]
  - 111 SHR: logical A>>1, C=A[0]
- Flags:
  - C = unsigned carry-out of the N-bit sum. For SUB, C = NOT borrow (1 when A >= B unsigned).
  - Z = (res == 0).
  - NEG = res[N-1].
  - V = signed overflow for ADD/SUB/ADDC; 0 for all other ops.
  - C = 0 for AND/OR/XOR.
- Handshake:
  - Transfer occurs when valid && ready are both high on a rising edge.
  - in_valid and the input data must be held until accepted.
  - out_res/out_flags are stable while out_valid && !out_ready.
- Pipeline:
  - Stage 1 registers the operands and opcode.
  - Stage 2 registers the result and flags; the compute happens on the S1->S2 move.
  - s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational, no in_valid dependency).
  - Latency: 2 cycles from acceptance to out_valid, with no stalls.
  - Throughput: 1 op/cycle when out_ready is held high.
  - Bubbles collapse; no transaction is dropped or duplicated; order is preserved.
- carry_q:
  - Updated with C when an ADD/SUB/ADDC/SHL/SHR op moves S1->S2.
  - Logic ops leave carry_q unchanged.
  - ADDC uses the carry_q value from before its own update.
- Arithmetic is computed at N+1 bits; the result is truncated to N bits (wrap).
- Reset (asynchronous, any time, including mid-stream):
  - s1_valid = s2_valid = 0, out_res = 0, out_flags = 0, carry_q = 0.
  - In-flight ops are discarded.
  - in_ready is 1 in the first cycle after deassertion.
- Simultaneous accept and drain with both stages full: all three transfers occur in the same cycle.

Optional Feature:
- ALU_SAT_EN defined: ADD, SUB and ADDC saturate as signed values. Positive overflow gives 0 followed by ones (max); negative overflow gives 1 followed by zeros (min). V=1 whenever saturation occurs. C, Z and NEG are computed from the saturated result, except C, which remains the raw carry.
- ALU_SAT_EN undefined: results wrap modulo 2^N; V still reports overflow.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD … OP_SHR), flag bit indices (FLG_C=3, FLG_Z=2, FLG_NEG=1, FLG_V=0), OPW.
- One sub-module, alu_core: purely combinational, parameter N, inputs (a, b, op, cin), outputs (res, flags, cout).
- The top level owns the pipeline registers, the handshake logic and carry_q.

Test Plan:
- N=8, out_ready=1: ADD 0xFF+0x01 at cycle t -> out_valid at t+2, res=0x00, flags C=1 Z=1 NEG=0 V=0.
- ADD 0xFF+0x01 then ADDC 0x00+0x00 back-to-back -> second result 0x01, C=0; then ADDC 0x00+0x00 -> 0x00, Z=1.
- SUB 0x80-0x01 -> res=0x7F, C=1, V=1. With ALU_SAT_EN -> res=0x80, V=1. Also SUB 0x03-0x05 -> 0xFE, C=0, NEG=1.
- Backpressure: issue 4 ops with out_ready=0 -> only 2 accepted and in_ready=0 until out_ready=1. Results then emerge in order, unchanged while stalled, with none lost.
- Assert rst_n low mid-stream with both stages full -> out_valid=0, out_res=0, out_flags=0 immediately. A following ADDC 0x01+0x01 gives 0x02 (carry_q cleared).
- 2000 random ops/operands with random out_ready, N=8 and N=16, checked against a scoreboard model including carry_q -> zero mismatches.
